// File: rtl/instr_fetch_unit_pkg.sv
// Shared parameters for the fetch stage, the multicycle control FSM and decode.
// Holds the instruction word width and the NOP encoding used when a fetch is
// aborted by the optional watchdog (FETCH_WATCHDOG_EN).
package instr_fetch_unit_pkg;

  localparam int BYTE_WIDTH        = 8;
  localparam int INSTRUCTION_WIDTH = 16;

  // Encoding the control FSM treats as "do nothing"; substituted on an abort.
  localparam logic [INSTRUCTION_WIDTH-1:0] INSTR_NOP = 16'hF000;

endpackage

// File: rtl/instr_fetch_unit_fetch_watchdog.sv
// Wait counter for the fetch stage watchdog. Only instantiated when
// FETCH_WATCHDOG_EN is defined. Counts cycles spent waiting on mem_ready in the
// current request state and flags the terminal cycle.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,   // FSM is changing state this cycle
  input  logic waiting,   // a request is outstanding and mem_ready=0
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: restart wins so every new request state begins at zero.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (waiting) begin
      count_d = count_q + CW'(1);
    end
  end

  // A ready on the terminal cycle is not "waiting", so it beats the timeout.
  assign timeout = waiting && (count_q == TERMINAL);

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads the high byte at pc, then the low byte
// at pc+1, and presents the big-endian 16-bit word with a one-cycle valid.
// Optional stall watchdog: define FETCH_WATCHDOG_EN to abort stuck fetches
// with INSTR_NOP and a sticky fetch_error.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH        = 16,
  parameter int INSTRUCTION_WIDTH = instr_fetch_unit_pkg::INSTRUCTION_WIDTH,
  parameter int TIMEOUT_CYCLES    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_start,
  input  logic [ADDR_WIDTH-1:0]        pc_in,
  input  logic [7:0]                   mem_rdata,
  input  logic                         mem_ready,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         instr_valid,
  output logic                         busy,
  output logic                         fetch_error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_HI = 2'd1;
  localparam logic [1:0] REQ_LO = 2'd2;

  // First byte read from memory lands in the upper half of the word.
  localparam bit BIG_ENDIAN = 1'b1;

  if (INSTRUCTION_WIDTH != 2 * BYTE_WIDTH || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("instr_fetch_unit: INSTRUCTION_WIDTH must be 16 and TIMEOUT_CYCLES >= 2");
  end

  logic [1:0]                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic [7:0]                   hi_q, hi_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic                         valid_q, valid_d;
  logic                         error_q, error_d;
  logic                         timeout;
  logic [INSTRUCTION_WIDTH-1:0] assembled;

  assign assembled = BIG_ENDIAN ? {hi_q, mem_rdata} : {mem_rdata, hi_q};

`ifdef FETCH_WATCHDOG_EN
  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fetch_watchdog (
    .clk     (clk),
    .reset   (reset),
    .restart (state_d != state_q),
    .waiting ((state_q != IDLE) && !mem_ready),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state and datapath decisions for the fetch FSM.
  always_comb begin
    // NOTE: every _d gets a default up front so no path leaves a value unassigned, which would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    hi_d    = hi_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          pc_d    = pc_in;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (mem_ready) begin
          hi_d    = mem_rdata;
          state_d = REQ_LO;
        end else if (timeout) begin
          state_d = IDLE;
          instr_d = INSTR_NOP;
          valid_d = 1'b1;
          error_d = 1'b1;
        end
      end
      REQ_LO: begin
        if (mem_ready) begin
          instr_d = assembled;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          state_d = IDLE;
          instr_d = INSTR_NOP;
          valid_d = 1'b1;
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs decoded from registered state only.
  always_comb begin
    busy     = (state_q == REQ_HI) || (state_q == REQ_LO);
    mem_req  = busy;
    mem_addr = (state_q == REQ_LO) ? pc_q + ADDR_WIDTH'(1) : pc_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      hi_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fetch_error = error_q;

endmodule
